// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStabilize,
    StRun,
    StFault
  } seq_state_e;

  localparam int unsigned DefRstCycles  = 16;
  localparam int unsigned DefLockTimeout = 65536;
  localparam int unsigned DefLockStable = 256;
  localparam int unsigned DefLossFilter = 4;
  localparam int unsigned DefMaxRetries = 3;

  // Bits needed to count 0 .. max_val-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL control/status bundle between the lock sequencer and its surroundings.
interface pll_lock_sequencer_if;

  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retries;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_locked,
    input  restart_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output fault,
    output retries,
    output loss_cnt
  );

  modport slave (
    output pll_locked,
    output restart_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fault,
    input  retries,
    input  loss_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings a PLL out of reset, waits for a stable lock, supervises it in RUN and
// retries or faults on timeout.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = DefRstCycles,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned LOCK_STABLE  = DefLockStable,
  parameter int unsigned LOSS_FILTER  = DefLossFilter,
  parameter int unsigned MAX_RETRIES  = DefMaxRetries
) (
  input logic                 refclk,
  input logic                 rst,
  pll_lock_sequencer_if.master seq
);

  // One timer serves reset hold, lock timeout and stability count.
  localparam int unsigned TimerW = cnt_width(umax(RST_CYCLES, umax(LOCK_TIMEOUT, LOCK_STABLE)));
  localparam int unsigned LfW    = cnt_width(LOSS_FILTER);

  localparam logic [TimerW-1:0] RstLast     = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(LOCK_STABLE - 1);
  localparam logic [LfW-1:0]    LfLast      = LfW'(LOSS_FILTER - 1);
  localparam logic [1:0]        RetryMax    = 2'(MAX_RETRIES);

  seq_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [LfW-1:0]    lf_q, lf_d;
  logic [1:0]        retries_q, retries_d, retry_inc;
  logic [7:0]        loss_cnt_q, loss_cnt_d;
  logic              pll_rst_q, sys_rst_q, ready_q, fault_q;
  logic              locked_s;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (seq.pll_locked),
    .q   (locked_s)
  );

  assign retry_inc = retries_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lf_d       = lf_q;
    retries_d  = retries_q;
    loss_cnt_d = loss_cnt_q;
    if (seq.restart_req) begin
      state_d   = StResetPll;
      timer_d   = '0;
      lf_d      = '0;
      retries_d = '0;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StWaitLock: begin
          // Lock is checked first so it wins over a coincident timeout.
          if (locked_s) begin
            state_d = StStabilize;
            timer_d = '0;
          end else if (timer_q == TimeoutLast) begin
            timer_d   = '0;
            retries_d = retry_inc;
            state_d   = (retry_inc == RetryMax) ? StFault : StResetPll;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StStabilize: begin
          if (!locked_s) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else if (timer_q == StableLast) begin
            state_d   = StRun;
            timer_d   = '0;
            lf_d      = '0;
            retries_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StRun: begin
          if (locked_s) begin
            lf_d = '0;
          end else if (lf_q == LfLast) begin
            state_d = StResetPll;
            timer_d = '0;
            lf_d    = '0;
            if (loss_cnt_q != 8'hFF) begin
              loss_cnt_d = loss_cnt_q + 8'd1;
            end
          end else begin
            lf_d = lf_q + 1'b1;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StResetPll;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change with the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= StResetPll;
      timer_q    <= '0;
      lf_q       <= '0;
      retries_q  <= '0;
      loss_cnt_q <= '0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lf_q       <= lf_d;
      retries_q  <= retries_d;
      loss_cnt_q <= loss_cnt_d;
      pll_rst_q  <= (state_d == StResetPll) || (state_d == StFault);
      sys_rst_q  <= (state_d != StRun);
      ready_q    <= (state_d == StRun);
      fault_q    <= (state_d == StFault);
    end
  end

  assign seq.pll_rst  = pll_rst_q;
  assign seq.sys_rst  = sys_rst_q;
  assign seq.ready    = ready_q;
  assign seq.fault    = fault_q;
  assign seq.retries  = retries_q;
  assign seq.loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  pll_lock_sequencer_if seq_if ();

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .LOSS_FILTER  (3),
    .MAX_RETRIES  (2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .seq    (seq_if)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int unsigned hold;
    bit          rst;
    bit          locked;
    logic        pll_rst;
    logic        sys_rst;
    logic        ready;
    logic        fault;
    logic [1:0]  retries;
    logic [7:0]  loss;
  } vec_t;

  vec_t vecs[13];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic adv(input int unsigned n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic pr, input logic sr, input logic rd,
                            input logic ft, input logic [1:0] rt, input logic [7:0] lc);
    check({tag, " pll_rst"}, {7'd0, seq_if.pll_rst}, {7'd0, pr});
    check({tag, " sys_rst"}, {7'd0, seq_if.sys_rst}, {7'd0, sr});
    check({tag, " ready"}, {7'd0, seq_if.ready}, {7'd0, rd});
    check({tag, " fault"}, {7'd0, seq_if.fault}, {7'd0, ft});
    check({tag, " retries"}, {6'd0, seq_if.retries}, {6'd0, rt});
    check({tag, " loss_cnt"}, seq_if.loss_cnt, lc);
  endtask

  task automatic apply_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rst                = vecs[i].rst;
      seq_if.pll_locked  = vecs[i].locked;
      seq_if.restart_req = 1'b0;
      adv(vecs[i].hold);
      check_outs($sformatf("row%0d", i), vecs[i].pll_rst, vecs[i].sys_rst, vecs[i].ready,
                 vecs[i].fault, vecs[i].retries, vecs[i].loss);
    end
  endtask

  task automatic pulse_restart();
    seq_if.restart_req = 1'b1;
    adv(1);
    seq_if.restart_req = 1'b0;
  endtask

  initial begin
    // hold, rst, locked | pll_rst, sys_rst, ready, fault, retries, loss
    vecs[0]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}; // reset
    vecs[1]  = '{3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}; // hold cycles 1-3
    vecs[2]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}; // WAIT_LOCK after 4
    vecs[3]  = '{5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}; // edge 9
    vecs[4]  = '{10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}; // edge 19
    vecs[5]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}; // RUN at 20
    vecs[6]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}; // 2-cycle glitch
    vecs[7]  = '{4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}; // glitch ignored
    vecs[8]  = '{4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}; // 2 low seen
    vecs[9]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1}; // 3rd low: loss
    vecs[10] = '{4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[11] = '{8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[12] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1};

    seq_if.pll_locked  = 1'b0;
    seq_if.restart_req = 1'b0;
    apply_rows(0, 12);

    // Restart coinciding with the third filtered low: a single reset entry.
    seq_if.pll_locked = 1'b0;
    adv(4);
    check_outs("loss_pending", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1);
    pulse_restart();
    check_outs("restart_run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    adv(3);
    check_outs("restart_hold", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    adv(1);
    check_outs("restart_wait", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);

    // Two timeouts lead to FAULT.
    adv(31);
    check_outs("to1_before", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    adv(1);
    check_outs("to1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    adv(35);
    check_outs("to2_before", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    adv(1);
    check_outs("fault", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1);
    adv(20);
    check_outs("fault_stay", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1);

    // Restart out of FAULT.
    pulse_restart();
    check_outs("fault_restart", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    adv(3);
    check_outs("fault_rst_hold", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    adv(1);
    check_outs("fault_rst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);

    // Unstable lock with retries=1: drop at STABILIZE cycle 5, then relock.
    adv(32);
    check_outs("unst_to", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    adv(4);
    check_outs("unst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    seq_if.pll_locked = 1'b1;
    adv(5);
    check_outs("unst_stab", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    seq_if.pll_locked = 1'b0;
    adv(3);
    check_outs("unst_drop", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    seq_if.pll_locked = 1'b1;
    adv(10);
    check_outs("unst_relock", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    adv(1);
    check_outs("unst_run", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1);

    // Reach WAIT_LOCK with retries=1, then pulse rst and rerun the start-up.
    seq_if.pll_locked = 1'b0;
    pulse_restart();
    check_outs("pre_rst_restart", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
    adv(36);
    check_outs("pre_rst_to", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    adv(9);
    check_outs("pre_rst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    apply_rows(0, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, giving the cycles pll_rst is held high per attempt (minimum 1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65536, giving the cycles to wait for lock per attempt (about 1.3 ms at 50 MHz).
REQ-003 The block SHALL have parameter LOCK_STABLE, default 256, giving the consecutive synchronized-locked cycles required before RUN.
REQ-004 The block SHALL have parameter LOSS_FILTER, default 4, giving the consecutive synchronized-unlocked cycles in RUN that count as lock loss.
REQ-005 The block SHALL have parameter MAX_RETRIES, default 3, giving the timed-out attempts allowed before FAULT.
REQ-006 The block SHALL have port refclk, input, 1 bit: the 50 MHz reference clock and the only clock.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port pll_locked, input, 1 bit: the PLL locked flag, asynchronous to refclk.
REQ-009 The block SHALL have port restart_req, input, 1 bit: a single-cycle pulse requesting PLL re-initialisation.
REQ-010 The block SHALL have port pll_rst, output, 1 bit: drives the PLL reset.
REQ-011 The block SHALL have port sys_rst, output, 1 bit: reset for the pixel-clock logic (VGA timing); the consumer synchronizes it.
REQ-012 The block SHALL have port ready, output, 1 bit: high only while in RUN.
REQ-013 The block SHALL have port fault, output, 1 bit: high only while in FAULT.
REQ-014 The block SHALL have port retries, output, 2 bits: the current timed-out attempt count.
REQ-015 The block SHALL have port loss_cnt, output, 8 bits: the RUN-state lock-loss event count, saturating at 255.

Function
REQ-016 pll_locked SHALL pass through a two-flop synchronizer; locked_s lags the input by 2 cycles.
REQ-017 The FSM SHALL have exactly five states: RESET_PLL, WAIT_LOCK, STABILIZE, RUN and FAULT.
REQ-018 In RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then the FSM SHALL enter WAIT_LOCK with the timer at 0.
REQ-019 In WAIT_LOCK: pll_rst=0 and the timer increments; if locked_s=1, the FSM SHALL enter STABILIZE with the timer at 0.
REQ-020 In WAIT_LOCK, if the timer reaches LOCK_TIMEOUT-1 without lock: retries SHALL increment; if the new value equals MAX_RETRIES the FSM SHALL enter FAULT, else RESET_PLL.
REQ-021 If lock and timeout occur in the same cycle, lock SHALL win.
REQ-022 In STABILIZE: locked_s=0 SHALL return the FSM to WAIT_LOCK with the timer cleared and retries unchanged; LOCK_STABLE consecutive locked cycles SHALL enter RUN.
REQ-023 On entering RUN, retries SHALL clear to 0.
REQ-024 In RUN: sys_rst=0 and ready=1; a locked_s low pulse shorter than LOSS_FILTER cycles SHALL be ignored and the filter counter cleared.
REQ-025 In RUN, LOSS_FILTER consecutive locked_s=0 cycles SHALL enter RESET_PLL and increment loss_cnt, saturating at 255.
REQ-026 In FAULT: pll_rst=1, fault=1, and the FSM SHALL stay in FAULT until rst or restart_req.
REQ-027 restart_req SHALL, in any state, enter RESET_PLL with the counter at 0 and retries cleared; it SHALL take priority over every other transition in that cycle.
REQ-028 sys_rst SHALL be 1 in every state except RUN, and SHALL go low on the first RUN cycle.
REQ-029 All outputs SHALL be registered.
REQ-030 Counter widths SHALL be $clog2 of their parameter maximum, and counters SHALL never wrap.

Reset
REQ-031 rst=1 SHALL force state=RESET_PLL and clear all counters, with outputs pll_rst=1, sys_rst=1, ready=0, fault=0, retries=0 and loss_cnt=0 on the next edge.
REQ-032 rst asserted mid-operation, in any state, SHALL restart the full sequence; the synchronizer flops SHALL clear to 0.

Structure
REQ-033 Package pll_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 The synchronizer SHALL be sub-module sync_2ff, instantiated once.
REQ-035 The target is 150-250 lines of RTL.

Verification (bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, LOSS_FILTER=3, MAX_RETRIES=2)
REQ-036 Normal start: release rst, pll_locked=1 at cycle 10 -> pll_rst high for cycles 1-4, ready=1 and sys_rst=0 at cycle 10+2+8, retries=0.
REQ-037 Timeout to fault: pll_locked held 0 -> two reset/wait cycles of 4+32 each, then fault=1, retries=2, pll_rst=1, ready=0.
REQ-038 Glitch filter in RUN: pll_locked low for 2 cycles -> stays in RUN with loss_cnt=0; low for 3 cycles -> RESET_PLL, loss_cnt=1, sys_rst=1.
REQ-039 Unstable lock: pll_locked drops at STABILIZE cycle 5 -> WAIT_LOCK, retries unchanged; the full 8 cycles on relock then give RUN.
REQ-040 Restart: restart_req in FAULT -> RESET_PLL, fault=0, retries=0; restart_req in RUN with simultaneous lock loss -> one RESET_PLL entry.
REQ-041 Mid-sequence reset: rst pulsed during WAIT_LOCK with retries=1 -> retries=0 and pll_rst=1 on the next edge, and the sequence repeats as in REQ-036.
